// File: rtl/topk_32_drain.sv
// Top-K drain for the 32-wide bitonic backend: buffers the first K ranks of each
// sorted vector and serialises them onto a valid/ready element stream.
package topk_32_drain_pkg;
  typedef struct packed {
    logic valid;
  } ctrl_t;
endpackage

module topk_32_drain
  import topk_32_drain_pkg::*;
#(
  parameter int unsigned DATAWIDTH  = 8,
  parameter int unsigned DATALENGTH = 32,
  parameter int unsigned K          = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  ctrl_t                                 ctrl_i,
  input  logic [DATALENGTH-1:0][DATAWIDTH-1:0]  x_i,
  output logic                                  space_o,
  output logic                                  overflow_o,
  output logic [DATAWIDTH-1:0]                  y_o,
  output logic [((K > 1) ? $clog2(K) : 1)-1:0]  rank_o,
  output logic                                  y_valid_o,
  input  logic                                  y_ready_i,
  output logic                                  y_last_o,
  output logic [$clog2(DEPTH+1)-1:0]            count_o
);

  localparam int unsigned RW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                                 state;
  logic [DEPTH-1:0][K-1:0][DATAWIDTH-1:0] mem;
  logic [PW-1:0]                          wptr;
  logic [PW-1:0]                          rptr;
  logic [PW-1:0]                          rptr_nxt;
  logic [RW-1:0]                          rank_nxt;
  logic [CW-1:0]                          count_nxt;
  logic [DATAWIDTH-1:0]                   y_nxt;
  logic                                   hs;
  logic                                   fin;
  logic                                   cap;
  logic                                   valid_nxt;

  // Ranks beyond K are never stored.
  if (K < DATALENGTH) begin : g_unused
    logic unused_ranks;
    assign unused_ranks = ^x_i[DATALENGTH-1:K];
  end

  // Handshake, capture decision and the element to present after this edge.
  always_comb begin
    hs        = (state == SEND) && y_ready_i;
    fin       = hs && y_last_o;
    space_o   = (count_o < CW'(DEPTH)) || fin;
    cap       = ctrl_i.valid && space_o;
    count_nxt = count_o + CW'(cap) - CW'(fin);
    rptr_nxt  = fin ? rptr + PW'(1) : rptr;
    rank_nxt  = rank_o;
    if (hs) begin
      rank_nxt = y_last_o ? '0 : rank_o + RW'(1);
    end
    valid_nxt = (count_nxt != '0);
    y_nxt     = '0;
    // A vector landing in the slot read next is forwarded straight from x_i.
    if (valid_nxt) begin
      y_nxt = (cap && (wptr == rptr_nxt)) ? x_i[0] : mem[rptr_nxt][rank_nxt];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      wptr       <= '0;
      rptr       <= '0;
      count_o    <= '0;
      rank_o     <= '0;
      y_o        <= '0;
      y_valid_o  <= 1'b0;
      y_last_o   <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      if (cap) begin
        mem[wptr] <= x_i[K-1:0];
        wptr      <= wptr + PW'(1);
      end
      case (state)
        IDLE:    if (cap) state <= SEND;
        SEND:    if (fin && (count_nxt == '0)) state <= IDLE;
        default: state <= IDLE;
      endcase
      rptr       <= rptr_nxt;
      count_o    <= count_nxt;
      rank_o     <= rank_nxt;
      y_o        <= y_nxt;
      y_valid_o  <= valid_nxt;
      y_last_o   <= valid_nxt && (rank_nxt == RW'(K - 1));
      overflow_o <= overflow_o || (ctrl_i.valid && !space_o);
    end
  end

endmodule

// File: tb/tb_topk_32_drain.sv
// Directed bench for topk_32_drain with default parameters (K=8, DEPTH=4).
module tb_topk_32_drain;
  import topk_32_drain_pkg::*;

  logic             clk_i = 1'b0;
  logic             rst_i;
  ctrl_t            ctrl_i;
  logic [31:0][7:0] x_i;
  logic             space_o;
  logic             overflow_o;
  logic [7:0]       y_o;
  logic [2:0]       rank_o;
  logic             y_valid_o;
  logic             y_ready_i;
  logic             y_last_o;
  logic [2:0]       count_o;

  int tests = 0;
  int fails = 0;

  topk_32_drain dut (
    .clk_i(clk_i), .rst_i(rst_i), .ctrl_i(ctrl_i), .x_i(x_i),
    .space_o(space_o), .overflow_o(overflow_o), .y_o(y_o), .rank_o(rank_o),
    .y_valid_o(y_valid_o), .y_ready_i(y_ready_i), .y_last_o(y_last_o),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_vec(input int tag, input int step);
    for (int j = 0; j < 32; j++) x_i[j] = 8'(tag + step * j);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; ctrl_i.valid = 1'b0; y_ready_i = 1'b0;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; ctrl_i.valid = 1'b0; y_ready_i = 1'b0; x_i = '0;
    tick(); tick();
    rst_i = 1'b0;
    tests++; if (y_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %0d want 0", y_valid_o); end
    tests++; if (y_last_o !== 1'b0) begin fails++; $display("FAIL reset_last got %0d want 0", y_last_o); end
    tests++; if (y_o !== 8'd0) begin fails++; $display("FAIL reset_y got %0d want 0", y_o); end
    tests++; if (rank_o !== 3'd0) begin fails++; $display("FAIL reset_rank got %0d want 0", rank_o); end
    tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count_o); end
    tests++; if (space_o !== 1'b1) begin fails++; $display("FAIL reset_space got %0d want 1", space_o); end
    tests++; if (overflow_o !== 1'b0) begin fails++; $display("FAIL reset_overflow got %0d want 0", overflow_o); end
  endtask

  task automatic test_single();
    do_reset();
    ctrl_i.valid = 1'b1; set_vec(0, 1); y_ready_i = 1'b1;
    tick();
    ctrl_i.valid = 1'b0;
    tests++; if (count_o !== 3'd1) begin fails++; $display("FAIL single_count got %0d want 1", count_o); end
    for (int i = 0; i < 8; i++) begin
      tests++; if (y_valid_o !== 1'b1) begin fails++; $display("FAIL single_valid beat %0d got %0d want 1", i, y_valid_o); end
      tests++; if (y_o !== 8'(i)) begin fails++; $display("FAIL single_y beat %0d got %0d want %0d", i, y_o, i); end
      tests++; if (rank_o !== 3'(i)) begin fails++; $display("FAIL single_rank beat %0d got %0d want %0d", i, rank_o, i); end
      tests++; if (y_last_o !== (i == 7)) begin fails++; $display("FAIL single_last beat %0d got %0d want %0d", i, y_last_o, i == 7); end
      tick();
    end
    tests++; if (y_valid_o !== 1'b0) begin fails++; $display("FAIL single_end_valid got %0d want 0", y_valid_o); end
    tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL single_end_count got %0d want 0", count_o); end
  endtask

  task automatic test_toggle();
    int n = 0;
    do_reset();
    ctrl_i.valid = 1'b1; set_vec(0, 1);
    tick();
    ctrl_i.valid = 1'b0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      y_ready_i = (c % 2 == 0);
      tests++; if (y_valid_o !== 1'b1) begin fails++; $display("FAIL toggle_valid cyc %0d got %0d want 1", c, y_valid_o); end
      tests++; if (y_o !== 8'(n)) begin fails++; $display("FAIL toggle_y cyc %0d got %0d want %0d", c, y_o, n); end
      tests++; if (rank_o !== 3'(n)) begin fails++; $display("FAIL toggle_rank cyc %0d got %0d want %0d", c, rank_o, n); end
      tests++; if (y_last_o !== (n == 7)) begin fails++; $display("FAIL toggle_last cyc %0d got %0d want %0d", c, y_last_o, n == 7); end
      if (y_ready_i) n++;
      tick();
    end
    y_ready_i = 1'b0;
    tests++; if (n != 8) begin fails++; $display("FAIL toggle_handshakes got %0d want 8", n); end
    tests++; if (y_valid_o !== 1'b0) begin fails++; $display("FAIL toggle_end_valid got %0d want 0", y_valid_o); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int v = 0; v < 5; v++) begin
      ctrl_i.valid = 1'b1; set_vec(10 + v, 16);
      tests++; if (space_o !== (v < 4)) begin fails++; $display("FAIL ovf_space v %0d got %0d want %0d", v, space_o, v < 4); end
      tick();
      tests++; if (count_o !== 3'((v < 4) ? v + 1 : 4)) begin fails++; $display("FAIL ovf_count v %0d got %0d", v, count_o); end
      tests++; if (overflow_o !== (v == 4)) begin fails++; $display("FAIL ovf_flag v %0d got %0d want %0d", v, overflow_o, v == 4); end
    end
    ctrl_i.valid = 1'b0;
    tests++; if (space_o !== 1'b0) begin fails++; $display("FAIL ovf_full_space got %0d want 0", space_o); end
    y_ready_i = 1'b1;
    for (int v = 0; v < 4; v++) begin
      for (int r = 0; r < 8; r++) begin
        tests++; if (y_valid_o !== 1'b1) begin fails++; $display("FAIL ovf_drain_valid v %0d r %0d got %0d", v, r, y_valid_o); end
        tests++; if (y_o !== 8'(10 + v + 16 * r)) begin fails++; $display("FAIL ovf_drain_y v %0d r %0d got %0d want %0d", v, r, y_o, 10 + v + 16 * r); end
        tick();
      end
    end
    tests++; if (y_valid_o !== 1'b0) begin fails++; $display("FAIL ovf_end_valid got %0d want 0", y_valid_o); end
    tests++; if (overflow_o !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %0d want 1", overflow_o); end
  endtask

  task automatic test_full_simul();
    do_reset();
    for (int v = 0; v < 4; v++) begin
      ctrl_i.valid = 1'b1; set_vec(20 + v, 16);
      tick();
    end
    ctrl_i.valid = 1'b0;
    tests++; if (count_o !== 3'd4) begin fails++; $display("FAIL simul_full_count got %0d want 4", count_o); end
    y_ready_i = 1'b1;
    for (int r = 0; r < 7; r++) tick();
    tests++; if (y_last_o !== 1'b1) begin fails++; $display("FAIL simul_last got %0d want 1", y_last_o); end
    ctrl_i.valid = 1'b1; set_vec(24, 16);
    tests++; if (space_o !== 1'b1) begin fails++; $display("FAIL simul_space got %0d want 1", space_o); end
    tick();
    ctrl_i.valid = 1'b0;
    tests++; if (count_o !== 3'd4) begin fails++; $display("FAIL simul_count got %0d want 4", count_o); end
    tests++; if (overflow_o !== 1'b0) begin fails++; $display("FAIL simul_overflow got %0d want 0", overflow_o); end
    for (int v = 1; v < 5; v++) begin
      for (int r = 0; r < 8; r++) begin
        tests++; if (y_o !== 8'(20 + v + 16 * r) || rank_o !== 3'(r)) begin fails++; $display("FAIL simul_drain v %0d r %0d got y %0d rank %0d want y %0d", v, r, y_o, rank_o, 20 + v + 16 * r); end
        tick();
      end
    end
    tests++; if (y_valid_o !== 1'b0) begin fails++; $display("FAIL simul_end_valid got %0d want 0", y_valid_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int v = 0; v < 3; v++) begin
      ctrl_i.valid = 1'b1; set_vec(100 + v, 16);
      tick();
    end
    ctrl_i.valid = 1'b0;
    y_ready_i = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    tests++; if (y_o !== 8'd149 || rank_o !== 3'd3) begin fails++; $display("FAIL mid_pos got y %0d rank %0d want y 149 rank 3", y_o, rank_o); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tests++; if (y_valid_o !== 1'b0) begin fails++; $display("FAIL mid_rst_valid got %0d want 0", y_valid_o); end
    tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL mid_rst_count got %0d want 0", count_o); end
    tests++; if (overflow_o !== 1'b0) begin fails++; $display("FAIL mid_rst_overflow got %0d want 0", overflow_o); end
    tests++; if (y_last_o !== 1'b0) begin fails++; $display("FAIL mid_rst_last got %0d want 0", y_last_o); end
    ctrl_i.valid = 1'b1; set_vec(200, 1);
    tick();
    ctrl_i.valid = 1'b0;
    for (int r = 0; r < 8; r++) begin
      tests++; if (y_valid_o !== 1'b1 || y_o !== 8'(200 + r) || rank_o !== 3'(r)) begin fails++; $display("FAIL mid_new r %0d got v %0d y %0d rank %0d want y %0d", r, y_valid_o, y_o, rank_o, 200 + r); end
      tick();
    end
    tests++; if (y_valid_o !== 1'b0) begin fails++; $display("FAIL mid_end_valid got %0d want 0", y_valid_o); end
  endtask

  task automatic test_back_to_back();
    int tags [5] = '{0, 1, 2, 3, 8};
    logic [9:0] accm = 10'b0100001111;
    int b;
    do_reset();
    y_ready_i = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      if (c < 10) begin
        ctrl_i.valid = 1'b1; set_vec(c, 16);
        tests++; if (space_o !== accm[c]) begin fails++; $display("FAIL b2b_space vec %0d got %0d want %0d", c, space_o, accm[c]); end
      end else begin
        ctrl_i.valid = 1'b0;
      end
      if (c >= 1) begin
        b = c - 1;
        tests++; if (y_valid_o !== 1'b1) begin fails++; $display("FAIL b2b_valid beat %0d got %0d want 1", b, y_valid_o); end
        tests++; if (y_o !== 8'(tags[b / 8] + 16 * (b % 8))) begin fails++; $display("FAIL b2b_y beat %0d got %0d want %0d", b, y_o, tags[b / 8] + 16 * (b % 8)); end
        tests++; if (y_last_o !== (b % 8 == 7)) begin fails++; $display("FAIL b2b_last beat %0d got %0d want %0d", b, y_last_o, b % 8 == 7); end
        tests++; if (overflow_o !== (c >= 5)) begin fails++; $display("FAIL b2b_overflow cyc %0d got %0d want %0d", c, overflow_o, c >= 5); end
      end
      tick();
    end
    tests++; if (y_valid_o !== 1'b0) begin fails++; $display("FAIL b2b_end_valid got %0d want 0", y_valid_o); end
    tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL b2b_end_count got %0d want 0", count_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_toggle();
    test_overflow();
    test_full_simul();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
